// File: rtl/instr_stream_feeder.sv
// instr_stream_feeder
//   Upstream instruction source for the sodor5 verification core. Holds a
//   loadable DEPTH-entry program buffer and drives one registered instruction
//   per clock; NOP_INSTR is driven whenever reset, idle, stopped or finished.
//
// Ports:
//   clk         single clock, all state updates on posedge
//   reset       synchronous, active-low reset
//   prog_we     program buffer write enable (accepted in any state)
//   prog_addr   write slot
//   prog_wdata  write data
//   prog_len    instructions to issue, 1..DEPTH (0 means DEPTH); sampled at start
//   loop_mode   1 = wrap to slot 0 after the last slot; sampled at start
//   start       begin issuing from slot 0
//   stop        abort issue (beats start and stall)
//   stall       core not accepting; hold output
//   instr       registered instruction to the core
//   instr_valid instr is a program word (0 = NOP filler)
//   issue_idx   slot of the word on instr
//   issue_cnt   words issued since the last start (wraps)
//   busy        in RUN state
//   done        one-shot finished; sticky until next start or reset
//
// Build option: FEEDER_BUBBLE_EN inserts one NOP bubble after every issued word.

module instr_stream_feeder #(
  parameter int unsigned          WORD_SIZE = 32,
  parameter int unsigned          DEPTH     = 16,
  parameter int unsigned          ADDR_W    = 4,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_we,
  input  logic [ADDR_W-1:0]    prog_addr,
  input  logic [WORD_SIZE-1:0] prog_wdata,
  input  logic [ADDR_W:0]      prog_len,
  input  logic                 loop_mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 stall,
  output logic [WORD_SIZE-1:0] instr,
  output logic                 instr_valid,
  output logic [ADDR_W-1:0]    issue_idx,
  output logic [31:0]          issue_cnt,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [WORD_SIZE-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0]    r_ptr;
  logic [ADDR_W:0]      r_len;
  logic                 r_loop;
  logic                 r_end;      // last word of a one-shot has been issued
  logic [WORD_SIZE-1:0] r_instr;
  logic                 r_valid;
  logic [ADDR_W-1:0]    r_idx;
  logic [31:0]          r_cnt;
  logic                 r_busy;
  logic                 r_done;
`ifdef FEEDER_BUBBLE_EN
  logic                 r_bub;      // next non-stalled slot is a bubble
`endif

  logic [WORD_SIZE-1:0] w_rd;
  logic [ADDR_W:0]      w_len;
  logic                 w_last;

  assign w_rd   = r_mem[r_ptr];
  assign w_len  = (prog_len == '0) ? (ADDR_W+1)'(DEPTH) : prog_len;
  assign w_last = ({1'b0, r_ptr} == (r_len - (ADDR_W+1)'(1)));

  // No reset on the buffer: contents survive reset. The read port samples
  // r_mem before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ptr   <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_end   <= 1'b0;
`ifdef FEEDER_BUBBLE_EN
      r_bub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
          if (stop) begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end else if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_len   <= w_len;
            r_loop  <= loop_mode;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_end   <= 1'b0;
`ifdef FEEDER_BUBBLE_EN
            r_bub   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (stop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
          end else if (!stall) begin
            // With bubbles enabled, the NOP entering DONE doubles as the
            // bubble that follows the last word.
            if (r_end) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_instr <= NOP_INSTR;
              r_valid <= 1'b0;
`ifdef FEEDER_BUBBLE_EN
            end else if (r_bub) begin
              r_instr <= NOP_INSTR;
              r_valid <= 1'b0;
              r_bub   <= 1'b0;
`endif
            end else begin
              r_instr <= w_rd;
              r_valid <= 1'b1;
              r_idx   <= r_ptr;
              r_cnt   <= r_cnt + 32'd1;
              if (w_last) begin
                r_ptr <= '0;
                if (!r_loop) r_end <= 1'b1;
              end else begin
                r_ptr <= r_ptr + ADDR_W'(1);
              end
`ifdef FEEDER_BUBBLE_EN
              r_bub   <= 1'b1;
`endif
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_instr <= NOP_INSTR;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign issue_idx   = r_idx;
  assign issue_cnt   = r_cnt;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_instr_stream_feeder.sv
// Testbench for instr_stream_feeder (default build): table-driven vectors
// for reset, one-shot, done handling and stall/stop, followed by hand-written
// sequences for loop wrap at full depth, write collision and mid-run reset.

module tb_instr_stream_feeder;

  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] W0  = 32'h00400093;
  localparam logic [31:0] W1  = 32'h14900093;
  localparam logic [31:0] W2  = 32'h26d08113;
  localparam logic [31:0] W3  = 32'h1df08113;
  localparam logic [31:0] WNEW = 32'h0af00013;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_wdata;
  logic [4:0]  prog_len;
  logic        loop_mode, start, stop, stall;
  logic [31:0] instr;
  logic        instr_valid;
  logic [3:0]  issue_idx;
  logic [31:0] issue_cnt;
  logic        busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_stream_feeder #(.WORD_SIZE(32), .DEPTH(16), .ADDR_W(4), .NOP_INSTR(32'h00000013)) dut (
    .clk(clk), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .loop_mode(loop_mode),
    .start(start), .stop(stop), .stall(stall), .instr(instr),
    .instr_valid(instr_valid), .issue_idx(issue_idx), .issue_cnt(issue_cnt),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic        rst_n, we;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [4:0]  len;
    logic        lp, st, sp, sl;
    logic [31:0] e_instr;
    logic        e_v;
    logic [3:0]  e_idx;
    logic [31:0] e_cnt;
    logic        e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst_n, logic we, logic [3:0] addr, logic [31:0] wd,
                              logic [4:0] len, logic lp, logic st, logic sp, logic sl,
                              logic [31:0] e_instr, logic e_v, logic [3:0] e_idx,
                              logic [31:0] e_cnt, logic e_busy, logic e_done);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.addr = addr; v.wd = wd; v.len = len;
    v.lp = lp; v.st = st; v.sp = sp; v.sl = sl;
    v.e_instr = e_instr; v.e_v = e_v; v.e_idx = e_idx; v.e_cnt = e_cnt;
    v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  function automatic logic [31:0] word(int unsigned i);
    return 32'hA0000013 + (i << 12);
  endfunction

  task automatic idle_inputs();
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    prog_len = 5'd4; loop_mode = 1'b0; start = 1'b0; stop = 1'b0; stall = 1'b0;
  endtask

  task automatic check(string name, logic [31:0] ei, logic ev, logic [3:0] eidx,
                       logic [31:0] ecnt, logic eb, logic ed);
    n_vec++;
    if (instr !== ei || instr_valid !== ev || issue_idx !== eidx ||
        issue_cnt !== ecnt || busy !== eb || done !== ed) begin
      n_err++;
      $display("FAIL %s: got instr=%h v=%0b idx=%0d cnt=%0d busy=%0b done=%0b, want instr=%h v=%0b idx=%0d cnt=%0d busy=%0b done=%0b",
               name, instr, instr_valid, issue_idx, issue_cnt, busy, done,
               ei, ev, eidx, ecnt, eb, ed);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;

    // Reset hold with buffer writes, then one-shot of 4 words.
    tbl.push_back(mk(0,1,4'd0,W0,5'd4,0,0,0,0, NOP,0,4'd0,0,0,0));
    tbl.push_back(mk(0,1,4'd1,W1,5'd4,0,1,0,0, NOP,0,4'd0,0,0,0));
    tbl.push_back(mk(0,1,4'd2,W2,5'd4,0,0,0,0, NOP,0,4'd0,0,0,0));
    tbl.push_back(mk(1,1,4'd3,W3,5'd4,0,0,0,0, NOP,0,4'd0,0,0,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,1,0,0, NOP,0,4'd0,0,1,0)); // edge N
    tbl.push_back(mk(1,0,4'd0,0 ,5'd0,1,0,0,0, W0 ,1,4'd0,1,1,0)); // len/mode latched at N
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W1 ,1,4'd1,2,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W2 ,1,4'd2,3,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W3 ,1,4'd3,4,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, NOP,0,4'd3,4,0,1)); // N+5 DONE
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,1, NOP,0,4'd3,4,0,1)); // sticky, stall ignored
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,1,0, NOP,0,4'd3,4,0,0)); // stop clears done
    // Loop run of 4 with stall on slot 2, start ignored in RUN, stop+stall.
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,1,1,0,0, NOP,0,4'd3,0,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W0 ,1,4'd0,1,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W1 ,1,4'd1,2,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W2 ,1,4'd2,3,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,1, W2 ,1,4'd2,3,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,1, W2 ,1,4'd2,3,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,1, W2 ,1,4'd2,3,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,1,0,0, W3 ,1,4'd3,4,1,0));
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, W0 ,1,4'd0,5,1,0)); // wrapped
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,1,1, NOP,0,4'd0,5,0,0)); // stop beats stall
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,1,1,0, NOP,0,4'd0,5,0,0)); // stop beats start
    tbl.push_back(mk(1,0,4'd0,0 ,5'd4,0,0,0,0, NOP,0,4'd0,5,0,0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst_n; prog_we = tbl[i].we; prog_addr = tbl[i].addr;
      prog_wdata = tbl[i].wd; prog_len = tbl[i].len; loop_mode = tbl[i].lp;
      start = tbl[i].st; stop = tbl[i].sp; stall = tbl[i].sl;
      tick();
      check($sformatf("vec%0d", i), tbl[i].e_instr, tbl[i].e_v, tbl[i].e_idx,
            tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_done);
    end
    idle_inputs();

    // Loop wrap at full depth (prog_len=0 means 16).
    for (int i = 0; i < 16; i++) begin
      prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = word(i);
      tick();
    end
    prog_we = 1'b0;
    prog_len = 5'd0; loop_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; prog_len = 5'd4; loop_mode = 1'b0;
    check("wrap_start", NOP, 0, 4'd0, 0, 1, 0);
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("wrap%0d", k), word((k-1) % 16), 1, 4'((k-1) % 16), 32'(k), 1, 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("wrap_stop", NOP, 0, 4'd7, 40, 0, 0);

    // Write collision on slot 5 in an 8-word loop.
    prog_len = 5'd8; loop_mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    check("coll_start", NOP, 0, 4'd7, 0, 1, 0);
    for (int k = 1; k <= 14; k++) begin
      if (k == 6) begin
        prog_we = 1'b1; prog_addr = 4'd5; prog_wdata = WNEW;
      end
      tick();
      prog_we = 1'b0;
      if (k == 14)
        check("coll_new", WNEW, 1, 4'd5, 32'(k), 1, 0);
      else
        check($sformatf("coll%0d", k), word((k-1) % 8), 1, 4'((k-1) % 8), 32'(k), 1, 0);
    end

    // Reset mid-run aborts immediately.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_midrun", NOP, 0, 4'd0, 0, 0, 0);
    tick();
    check("post_rst_idle", NOP, 0, 4'd0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_stream_feeder.md
Name: instr_stream_feeder

Overview:
- Upstream instruction source for the sodor5 verification core.
- Holds a loadable 16-entry program buffer and drives one registered 32-bit instruction per clock into the core's instruction input.
- Emits NOP (ADDI x0,x0,0 = 32'h00000013) whenever it is in reset, idle, stopped or finished.
- Runs in one-shot or looping mode, honours a core stall, and exposes issue index, issue count and status.

Parameters:
- WORD_SIZE, 32, instruction width in bits
- DEPTH, 16, program buffer entries (power of two)
- ADDR_W, 4, log2(DEPTH)
- NOP_INSTR, 32'h00000013, filler instruction

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  synchronous, active-low reset (asserted when 0)
- prog_we  input  1  program buffer write enable
- prog_addr  input  ADDR_W  write slot
- prog_wdata  input  WORD_SIZE  write data
- prog_len  input  ADDR_W+1  number of instructions to issue, 1..DEPTH; 0 is treated as DEPTH; sampled at start
- loop_mode  input  1  1 = wrap to slot 0 after the last slot; 0 = one-shot; sampled at start
- start  input  1  begin issuing from slot 0
- stop  input  1  abort issue
- stall  input  1  core not accepting; hold output
- instr  output  WORD_SIZE  registered instruction to the core
- instr_valid  output  1  instr is a program word (0 means NOP filler)
- issue_idx  output  ADDR_W  slot of the word currently on instr
- issue_cnt  output  32  words issued since the last start; wraps modulo 2^32
- busy  output  1  in RUN state
- done  output  1  one-shot finished; sticky until the next start or reset

Behaviour:
- Reset (reset==0 at a posedge):
  - state enters IDLE.
  - instr=NOP_INSTR, instr_valid=0, issue_idx=0, issue_cnt=0, busy=0, done=0.
  - Buffer contents are not cleared.
  - Reset mid-RUN aborts immediately: NOP is on instr at the next edge.
- Buffer:
  - Synchronous write when prog_we=1. Writes are accepted in any state.
  - Read of the slot being written in the same cycle returns the old contents (read-before-write).
- States: IDLE, RUN, DONE.
  - IDLE: outputs NOP, instr_valid=0.
    - start=1 → RUN. Latch len and mode, ptr=0, issue_cnt cleared.
    - start=1 and stop=1 together: stop wins, remain IDLE.
  - RUN, no stall:
    - Each edge: instr<=buf[ptr], instr_valid<=1, issue_idx<=ptr, issue_cnt+=1.
    - ptr advances; at ptr==len-1 it returns to 0.
    - Latency: start sampled at edge N → buf[0] on instr after edge N+1.
  - RUN, stall=1: instr, instr_valid, issue_idx, issue_cnt and ptr all hold.
  - RUN, end of program in one-shot mode: after the word at slot len-1 is issued, the next edge goes to DONE, with instr=NOP, instr_valid=0, done=1.
  - RUN, end of program in loop mode: wraps and keeps issuing indefinitely.
  - RUN, stop=1: the next edge goes to IDLE with instr=NOP and instr_valid=0; done is not set. stop takes priority over stall.
  - RUN, start=1 with stop=0: ignored.
  - DONE: outputs NOP.
    - start=1 → RUN (done clears on that edge).
    - stop=1 → IDLE (done clears).
- stall in IDLE or DONE: no effect.
- busy=1 exactly when state==RUN.

Optional Feature:
- Macro FEEDER_BUBBLE_EN.
- Defined:
  - After every issued program word, one NOP bubble is issued (instr_valid=0) before the next word. This gives hazard-free streams for model comparison.
  - Bubble cycles do not increment issue_cnt.
  - stall holds bubbles exactly as it holds words.
  - One-shot DONE is entered after the bubble that follows the last word.
- Undefined: back-to-back issue as described above.

Test Plan:
- Reset hold: reset=0 for 3 cycles with prog_we pulses → instr=32'h00000013, instr_valid=0, busy=0, issue_cnt=0 every cycle.
- One-shot: load slots 0..3 with 32'h00400093, 32'h14900093, 32'h26d08113, 32'h1df08113; prog_len=4; loop_mode=0; start pulse at edge N.
  - Those four words appear on edges N+1..N+4 with issue_idx 0..3.
  - NOP with done=1 from edge N+5; issue_cnt=4.
- Loop wrap: prog_len=0 (=16), loop_mode=1, run 40 cycles → issue_idx sequence 0..15,0..15,0..7; issue_cnt=40; slot 15 is followed by slot 0.
- Stall and stop:
  - stall=1 for 3 cycles while issuing slot 2 → slot 2 held 4 cycles total, issue_cnt unchanged while stalled.
  - stop=1 together with stall=1 → NOP and IDLE on the next edge; done=0.
- Write collision: in loop mode, write 32'h0af00013 to slot 5 in the same cycle slot 5 is read → old word issued; new word issued on the next pass.
- FEEDER_BUBBLE_EN: the one-shot case above yields word, NOP, word, NOP… and done after edge N+8; issue_cnt=4.
